// File: rtl/bram_pkg.sv
// bram_pkg: shared widths, requester ids, arbiter states and stats width for bram_arbiter
package bram_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
  localparam int STATS_W = 16;
  typedef enum logic {REQ_A, REQ_B} req_id_e;
  typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} arb_state_e;
endpackage

// File: rtl/bram_rr_pick.sv
// bram_rr_pick: two-way round-robin pick; a_valid/b_valid in, last_gnt in, one-hot a_pick/b_pick out
module bram_rr_pick
  import bram_pkg::*;
(
  input  logic    a_valid,
  input  logic    b_valid,
  input  req_id_e last_gnt,
  output logic    a_pick,
  output logic    b_pick
);
  always_comb begin
    a_pick = a_valid & (~b_valid | (last_gnt == REQ_B));
    b_pick = b_valid & (~a_valid | (last_gnt == REQ_A));
  end
endmodule

// File: rtl/bram_arbiter.sv
// bram_arbiter: two-requester round-robin BRAM arbiter with burst lock; ports a_/b_ req/rsp, bram_* port, optional stats counters under BRAM_ARB_STATS_EN
module bram_arbiter
  import bram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               a_req_valid,
  output logic               a_req_ready,
  input  logic               a_req_we,
  input  logic               a_req_lock,
  input  logic [ADDR_W-1:0]  a_req_addr,
  input  logic [DATA_W-1:0]  a_req_wdata,
  output logic               a_rsp_valid,
  output logic [DATA_W-1:0]  a_rsp_rdata,
  input  logic               b_req_valid,
  output logic               b_req_ready,
  input  logic               b_req_we,
  input  logic               b_req_lock,
  input  logic [ADDR_W-1:0]  b_req_addr,
  input  logic [DATA_W-1:0]  b_req_wdata,
  output logic               b_rsp_valid,
  output logic [DATA_W-1:0]  b_rsp_rdata,
`ifdef BRAM_ARB_STATS_EN
  output logic [STATS_W-1:0] a_grant_cnt,
  output logic [STATS_W-1:0] b_grant_cnt,
  output logic [STATS_W-1:0] conflict_cnt,
`endif
  output logic               bram_en,
  output logic               bram_we,
  output logic [ADDR_W-1:0]  bram_addr,
  output logic [DATA_W-1:0]  bram_wdata,
  input  logic [DATA_W-1:0]  bram_rdata
);
  arb_state_e state_q, state_d;
  req_id_e    last_gnt_q, last_gnt_d;
  logic       a_rsp_valid_q, a_rsp_valid_d, b_rsp_valid_q, b_rsp_valid_d;
  logic       a_pick, b_pick, a_acc, b_acc;
  bram_rr_pick u_pick (
    .a_valid (a_req_valid),
    .b_valid (b_req_valid),
    .last_gnt(last_gnt_q),
    .a_pick  (a_pick),
    .b_pick  (b_pick)
  );
  // ready is gated by rst_n so nothing is accepted or driven while reset is asserted
  always_comb begin
    a_req_ready = rst_n & ((state_q == LOCK_A) ? a_req_valid : (state_q == LOCK_B) ? 1'b0 : a_pick);
    b_req_ready = rst_n & ((state_q == LOCK_B) ? b_req_valid : (state_q == LOCK_A) ? 1'b0 : b_pick);
    a_acc = a_req_valid & a_req_ready;
    b_acc = b_req_valid & b_req_ready;
    bram_en = a_acc | b_acc;
    bram_we = a_acc ? a_req_we : b_acc & b_req_we;
    bram_addr = a_acc ? a_req_addr : b_acc ? b_req_addr : '0;
    bram_wdata = a_acc ? a_req_wdata : b_acc ? b_req_wdata : '0;
    last_gnt_d = a_acc ? REQ_A : b_acc ? REQ_B : last_gnt_q;
    // while locked, dropping lock ends the burst whether or not the holder issues a beat
    state_d = (state_q == LOCK_A) ? (a_req_lock ? LOCK_A : IDLE) :
              (state_q == LOCK_B) ? (b_req_lock ? LOCK_B : IDLE) :
              (a_acc & a_req_lock) ? LOCK_A :
              (b_acc & b_req_lock) ? LOCK_B : IDLE;
    a_rsp_valid_d = a_acc & ~a_req_we;
    b_rsp_valid_d = b_acc & ~b_req_we;
    a_rsp_valid = a_rsp_valid_q;
    b_rsp_valid = b_rsp_valid_q;
    a_rsp_rdata = a_rsp_valid_q ? bram_rdata : '0;
    b_rsp_rdata = b_rsp_valid_q ? bram_rdata : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_gnt_q <= REQ_A;
      a_rsp_valid_q <= 1'b0;
      b_rsp_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_gnt_q <= last_gnt_d;
      a_rsp_valid_q <= a_rsp_valid_d;
      b_rsp_valid_q <= b_rsp_valid_d;
    end
  end
`ifdef BRAM_ARB_STATS_EN
  logic [STATS_W-1:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d, cf_cnt_q, cf_cnt_d;
  always_comb begin
    a_cnt_d = (a_acc && a_cnt_q != '1) ? a_cnt_q + STATS_W'(1) : a_cnt_q;
    b_cnt_d = (b_acc && b_cnt_q != '1) ? b_cnt_q + STATS_W'(1) : b_cnt_q;
    cf_cnt_d = (a_req_valid && b_req_valid && bram_en && cf_cnt_q != '1) ? cf_cnt_q + STATS_W'(1) : cf_cnt_q;
    a_grant_cnt = a_cnt_q;
    b_grant_cnt = b_cnt_q;
    conflict_cnt = cf_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_cnt_q <= '0;
      b_cnt_q <= '0;
      cf_cnt_q <= '0;
    end else begin
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
      cf_cnt_q <= cf_cnt_d;
    end
  end
`endif
endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: directed self-checking bench for bram_arbiter with a behavioural BRAM
module tb_bram_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_req_valid, a_req_ready, a_req_we, a_req_lock, a_rsp_valid;
  logic b_req_valid, b_req_ready, b_req_we, b_req_lock, b_rsp_valid;
  logic [AW-1:0] a_req_addr, b_req_addr, bram_addr;
  logic [DW-1:0] a_req_wdata, b_req_wdata, a_rsp_rdata, b_rsp_rdata, bram_wdata, bram_rdata;
  logic bram_en, bram_we;
`ifdef BRAM_ARB_STATS_EN
  logic [15:0] a_grant_cnt, b_grant_cnt, conflict_cnt;
`endif
  logic [DW-1:0] mem [0:(1<<AW)-1];
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_wdata;
      bram_rdata <= mem[bram_addr];
    end
  end
  bram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we), .a_req_lock(a_req_lock),
    .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata), .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we), .b_req_lock(b_req_lock),
    .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata), .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
`ifdef BRAM_ARB_STATS_EN
    .a_grant_cnt(a_grant_cnt), .b_grant_cnt(b_grant_cnt), .conflict_cnt(conflict_cnt),
`endif
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
  );
  task automatic idle();
    a_req_valid = 0; a_req_we = 0; a_req_lock = 0; a_req_addr = '0; a_req_wdata = '0;
    b_req_valid = 0; b_req_we = 0; b_req_lock = 0; b_req_addr = '0; b_req_wdata = '0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    idle();
    rst_n = 0;
    #2;
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic test_reset();
    a_req_valid = 1; b_req_valid = 1; a_req_we = 1; a_req_addr = 10'h155; a_req_wdata = 32'hFFFF_FFFF;
    #2;
    n_chk++; if (a_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_a_ready got %b want 0", a_req_ready); end
    n_chk++; if (b_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_b_ready got %b want 0", b_req_ready); end
    n_chk++; if ({bram_en, bram_we} !== 2'b00) begin n_fail++; $display("FAIL reset_bram_en_we got %b want 00", {bram_en, bram_we}); end
    n_chk++; if (bram_addr !== '0 || bram_wdata !== '0) begin n_fail++; $display("FAIL reset_bram_addr_wdata got %h/%h want 0/0", bram_addr, bram_wdata); end
    tick();
    n_chk++; if ({a_rsp_valid, b_rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 00", {a_rsp_valid, b_rsp_valid}); end
    idle();
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic test_single_read();
    a_req_valid = 1; a_req_addr = 10'h005;
    #2;
    n_chk++; if ({a_req_ready, b_req_ready} !== 2'b10) begin n_fail++; $display("FAIL rd_ready got %b want 10", {a_req_ready, b_req_ready}); end
    n_chk++; if ({bram_en, bram_we} !== 2'b10 || bram_addr !== 10'h005) begin n_fail++; $display("FAIL rd_bram got en/we %b addr %h want 10 005", {bram_en, bram_we}, bram_addr); end
    tick();
    idle();
    n_chk++; if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_rsp got %b %h want 1 deadbeef", a_rsp_valid, a_rsp_rdata); end
    n_chk++; if (b_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_b_rsp got %b want 0", b_rsp_valid); end
    tick();
    n_chk++; if (a_rsp_valid !== 1'b0 || a_rsp_rdata !== '0) begin n_fail++; $display("FAIL rd_rsp_clear got %b %h want 0 0", a_rsp_valid, a_rsp_rdata); end
  endtask
  task automatic test_round_robin();
    logic exp_b;
    do_reset();
    a_req_valid = 1; b_req_valid = 1; a_req_addr = 10'h010; b_req_addr = 10'h020;
    for (int i = 0; i < 4; i++) begin
      exp_b = (i % 2 == 0);
      #2;
      n_chk++; if ({a_req_ready, b_req_ready} !== {~exp_b, exp_b}) begin n_fail++; $display("FAIL rr_grant%0d got a/b %b want %b", i, {a_req_ready, b_req_ready}, {~exp_b, exp_b}); end
      n_chk++; if (bram_addr !== (exp_b ? 10'h020 : 10'h010)) begin n_fail++; $display("FAIL rr_addr%0d got %h want %h", i, bram_addr, exp_b ? 10'h020 : 10'h010); end
      n_chk++; if ({a_rsp_valid, b_rsp_valid} !== {i > 0 && exp_b, i > 0 && !exp_b}) begin n_fail++; $display("FAIL rr_rsp%0d got a/b %b want %b", i, {a_rsp_valid, b_rsp_valid}, {i > 0 && exp_b, i > 0 && !exp_b}); end
      tick();
    end
    idle();
    n_chk++; if ({a_rsp_valid, b_rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL rr_rsp_last got %b want 10", {a_rsp_valid, b_rsp_valid}); end
    tick();
  endtask
  task automatic test_lock();
    do_reset();
    b_req_valid = 1; b_req_we = 1; b_req_addr = 10'h030; b_req_wdata = 32'h1;
    #2;
    n_chk++; if (b_req_ready !== 1'b1) begin n_fail++; $display("FAIL lock_pre_b got %b want 1", b_req_ready); end
    tick();
    a_req_valid = 1; a_req_we = 1; a_req_lock = 1;
    for (int i = 0; i < 5; i++) begin
      a_req_valid = (i != 2);
      a_req_lock = (i != 4);
      a_req_addr = 10'h040 + 10'(i);
      #2;
      n_chk++; if ({a_req_ready, b_req_ready} !== {i != 2, 1'b0}) begin n_fail++; $display("FAIL lock_beat%0d got a/b %b want %b", i, {a_req_ready, b_req_ready}, {i != 2, 1'b0}); end
      tick();
    end
    a_req_valid = 0; a_req_lock = 0;
    #2;
    n_chk++; if (b_req_ready !== 1'b1 || bram_addr !== 10'h030) begin n_fail++; $display("FAIL lock_release got b %b addr %h want 1 030", b_req_ready, bram_addr); end
    tick();
    idle();
  endtask
  task automatic test_abandon();
    do_reset();
    b_req_valid = 1; b_req_we = 1; b_req_addr = 10'h031;
    tick();
    a_req_valid = 1; a_req_we = 1; a_req_lock = 1;
    #2;
    n_chk++; if (a_req_ready !== 1'b1) begin n_fail++; $display("FAIL abandon_a_grant got %b want 1", a_req_ready); end
    tick();
    a_req_valid = 0; a_req_lock = 0;
    #2;
    n_chk++; if (b_req_ready !== 1'b0) begin n_fail++; $display("FAIL abandon_still_locked got %b want 0", b_req_ready); end
    tick();
    #2;
    n_chk++; if (b_req_ready !== 1'b1) begin n_fail++; $display("FAIL abandon_idle_b got %b want 1", b_req_ready); end
    tick();
    idle();
  endtask
  task automatic test_write_read();
    b_req_valid = 1; b_req_we = 1; b_req_addr = 10'h0AA; b_req_wdata = 32'h12345678;
    #2;
    n_chk++; if (b_req_ready !== 1'b1 || bram_we !== 1'b1 || bram_wdata !== 32'h12345678) begin n_fail++; $display("FAIL wr_bram got rdy %b we %b wdata %h want 1 1 12345678", b_req_ready, bram_we, bram_wdata); end
    tick();
    idle();
    a_req_valid = 1; a_req_addr = 10'h0AA;
    #2;
    n_chk++; if (b_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_no_rsp got %b want 0", b_rsp_valid); end
    tick();
    idle();
    n_chk++; if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 32'h12345678 || b_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rd_back got a %b %h b %b want 1 12345678 0", a_rsp_valid, a_rsp_rdata, b_rsp_valid); end
    tick();
  endtask
  task automatic test_reset_mid_burst();
    a_req_valid = 1; a_req_lock = 1; a_req_addr = 10'h005;
    tick();
    a_req_we = 1; a_req_addr = 10'h006; a_req_wdata = 32'hCAFE_0000;
    n_chk++; if (a_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL mid_inflight got %b want 1", a_rsp_valid); end
    rst_n = 0;
    #1;
    n_chk++; if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b0) begin n_fail++; $display("FAIL mid_async got rsp %b rdy %b want 0 0", a_rsp_valid, a_req_ready); end
    n_chk++; if ({bram_en, bram_we} !== 2'b00 || bram_addr !== '0 || bram_wdata !== '0) begin n_fail++; $display("FAIL mid_bram got en/we %b addr %h wdata %h want 00 0 0", {bram_en, bram_we}, bram_addr, bram_wdata); end
    idle();
    @(negedge clk);
    rst_n = 1;
    b_req_valid = 1; b_req_addr = 10'h005;
    #2;
    n_chk++; if (b_req_ready !== 1'b1 || a_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_post got b_rdy %b a_rsp %b want 1 0", b_req_ready, a_rsp_valid); end
    tick();
    idle();
    n_chk++; if ({a_rsp_valid, b_rsp_valid} !== 2'b01 || b_rsp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL mid_post_rsp got %b %h want 01 deadbeef", {a_rsp_valid, b_rsp_valid}, b_rsp_rdata); end
    tick();
  endtask
`ifdef BRAM_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    a_req_valid = 1; a_req_we = 1; a_req_lock = 1;
    b_req_valid = 1; b_req_we = 1;
    for (int i = 0; i < 70000; i++) tick();
    idle();
    n_chk++; if (a_grant_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL stats_a got %h want ffff", a_grant_cnt); end
    n_chk++; if (b_grant_cnt !== 16'h0001) begin n_fail++; $display("FAIL stats_b got %h want 0001", b_grant_cnt); end
    n_chk++; if (conflict_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL stats_conflict got %h want ffff", conflict_cnt); end
    tick();
  endtask
`endif
  initial begin
    mem[10'h005] = 32'hDEADBEEF;
    bram_rdata = '0;
    idle();
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock();
    test_abandon();
    test_write_read();
    test_reset_mid_burst();
`ifdef BRAM_ARB_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
